// File: rtl/imem_fetch_ctrl_pkg.sv
// fetch_pkg: shared FSM encoding, word size and fetch address checks for imem_fetch_ctrl
package fetch_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, FAULT = 2'd2} state_e;
  localparam int WORD_BYTES = 4;
  function automatic logic in_range(input logic [63:0] pc, input int n);
    return (pc >> (n + 2)) == 64'd0;
  endfunction
  function automatic logic aligned(input logic [1:0] lo);
    return lo == 2'd0;
  endfunction
endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo: sync prefetch FIFO with flush, combinational head that holds its last value when empty
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [W-1:0] hold_q;
  logic do_push, do_pop;
  always_comb begin
    empty_o = cnt_q == '0;
    full_o  = cnt_q == (AW+1)'(DEPTH);
    do_push = push_i && (!full_o || pop_i);
    do_pop  = pop_i && !empty_o;
    dout_o  = empty_o ? hold_q : mem_q[rd_q];
  end
  always_ff @(posedge clk)
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      hold_q <= dout_o;
      if (flush_i) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
        rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
        cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
    end
  end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: imem fetch sequencer; clk/reset, imem_addr/imem_rd, halt, redirect_valid/pc, inst_valid/inst/inst_pc/inst_ready to decode, fault
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int             WIDTH    = 32,
  parameter int             N        = 6,
  parameter int             DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rd,
  input  logic             halt,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready,
  output logic             fault
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [2*WIDTH-1:0] head;
  logic full, empty, pop, push, pc_ok, redir_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end
  always_comb begin
    pc_ok    = in_range(64'(fetch_pc_q), N);
    redir_ok = in_range(64'(redirect_pc), N) && aligned(redirect_pc[1:0]);
    state_d  = state_q;
    if (redirect_valid) state_d = !redir_ok ? FAULT : halt ? HALT : RUN;
    else if (state_q == RUN) state_d = !pc_ok ? FAULT : halt ? HALT : RUN;
    else if (state_q == HALT) state_d = halt ? HALT : RUN;
  end
  always_comb begin
    inst_valid = !empty;
    pop        = inst_valid && inst_ready;
    push       = state_q == RUN && !halt && pc_ok && (!full || pop) && !redirect_valid;
    fetch_pc_d = redirect_valid ? redirect_pc : push ? fetch_pc_q + WIDTH'(WORD_BYTES) : fetch_pc_q;
    fault      = state_q == FAULT;
    imem_addr  = fetch_pc_q;
    inst_pc    = head[2*WIDTH-1:WIDTH];
    inst       = head[WIDTH-1:0];
  end
  fetch_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({fetch_pc_q, imem_rd}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: scoreboard bench for imem_fetch_ctrl with a 64-word imem holding 32'h1000_0000+i
module tb_imem_fetch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halt = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic inst_ready = 1'b0;
  logic [31:0] imem_addr, imem_rd, inst, inst_pc;
  logic inst_valid, fault;
  logic [31:0] imem [64];
  logic [63:0] exp_q [$];
  logic [63:0] e;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  initial for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 + i;
  assign imem_rd = imem[imem_addr[7:2]];
  imem_fetch_ctrl #(.WIDTH(32), .N(6), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fault          (fault)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_word(input logic [31:0] pc, input logic [31:0] w);
    exp_q.push_back({pc, w});
  endtask
  task automatic do_reset();
    step();
    reset = 1'b1;
    inst_ready = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask
  always @(negedge clk)
    if (!reset && !redirect_valid && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_delivery: got pc=%h inst=%h expected none", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        chk("deliver_pc", inst_pc, e[63:32]);
        chk("deliver_inst", inst, e[31:0]);
      end
    end
  initial begin
    step();
    step();
    @(negedge clk);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    // T1
    step();
    reset = 1'b0;
    inst_ready = 1'b1;
    expect_word(32'h0, 32'h1000_0000);
    expect_word(32'h4, 32'h1000_0001);
    expect_word(32'h8, 32'h1000_0002);
    @(negedge clk);
    chk("t1_first_cycle_valid", 32'(inst_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t1_second_cycle_valid", 32'(inst_valid), 32'd1);
    chk("t1_second_cycle_pc", inst_pc, 32'h0);
    step();
    step();
    step();
    inst_ready = 1'b0;
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    // T2
    do_reset();
    repeat (4) step();
    @(negedge clk);
    chk("t2_stall_addr", imem_addr, 32'h8);
    chk("t2_head_valid", 32'(inst_valid), 32'd1);
    chk("t2_head_pc", inst_pc, 32'h0);
    step();
    inst_ready = 1'b1;
    expect_word(32'h0, 32'h1000_0000);
    expect_word(32'h4, 32'h1000_0001);
    expect_word(32'h8, 32'h1000_0002);
    repeat (3) step();
    inst_ready = 1'b0;
    chk("t2_drained", 32'(exp_q.size()), 32'd0);
    // T3
    do_reset();
    repeat (5) step();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    expect_word(32'h40, 32'h1000_0010);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_flushed_valid", 32'(inst_valid), 32'd0);
    step();
    step();
    inst_ready = 1'b0;
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    // T4
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hF0;
    inst_ready = 1'b1;
    expect_word(32'hF0, 32'h1000_003C);
    expect_word(32'hF4, 32'h1000_003D);
    expect_word(32'hF8, 32'h1000_003E);
    expect_word(32'hFC, 32'h1000_003F);
    step();
    redirect_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("t4_fault_before_wrap", 32'(fault), 32'd0);
    step();
    @(negedge clk);
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_fault_valid", 32'(inst_valid), 32'd0);
    chk("t4_fault_addr", imem_addr, 32'h100);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    expect_word(32'h0, 32'h1000_0000);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_fault_cleared", 32'(fault), 32'd0);
    step();
    step();
    inst_ready = 1'b0;
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    // T5
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_misaligned_fault", 32'(fault), 32'd1);
    chk("t5_misaligned_valid", 32'(inst_valid), 32'd0);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    inst_ready = 1'b1;
    expect_word(32'h8, 32'h1000_0002);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_recovered", 32'(fault), 32'd0);
    step();
    step();
    inst_ready = 1'b0;
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    // T6
    do_reset();
    inst_ready = 1'b1;
    expect_word(32'h0, 32'h1000_0000);
    expect_word(32'h4, 32'h1000_0001);
    expect_word(32'h8, 32'h1000_0002);
    expect_word(32'hC, 32'h1000_0003);
    step();
    step();
    halt = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("t6_halt_valid", 32'(inst_valid), 32'd0);
    chk("t6_halt_addr", imem_addr, 32'h8);
    step();
    step();
    halt = 1'b0;
    repeat (4) step();
    inst_ready = 1'b0;
    step();
    @(negedge clk);
    chk("t6_full_valid", 32'(inst_valid), 32'd1);
    chk("t6_full_head", inst_pc, 32'h10);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 32'(inst_valid), 32'd0);
    chk("t6_rst_fault", 32'(fault), 32'd0);
    chk("t6_rst_addr", imem_addr, 32'h0);
    chk("t6_rst_inst_pc", inst_pc, 32'h0);
    chk("t6_rst_inst", inst, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
